// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Smallest ratio that still yields a real high and low phase.
  localparam int DIV_MIN = 2;

endpackage

// File: rtl/clk_div_core.sv
// Period generator: cnt/pos on posedge, neg on negedge, clk_out = pos | neg.
// Odd ratios get the extra half-cycle of high time from the negedge register.
// The ratio input is sampled at the wrap edge, so a new ratio always starts
// a fresh period with cnt=0.
module clk_div_core #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,    // RUN or DRAIN: counter advances
  input  logic             start,  // STOP->RUN on this edge
  input  logic             halt,   // at wrap, park in STOP instead of restarting
  input  logic [CNT_W-1:0] div,    // ratio in effect (updated by ctrl at wrap)
  output logic             wrap,
  output logic             clk_out
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] half;
  logic             pos;
  logic             neg;

  assign half    = div >> 1;
  assign cnt_inc = cnt + 1'b1;
  assign wrap    = run && (cnt == div - 1'b1);
  assign clk_out = pos | neg;

  // Counter and high-phase register; pos is always 1 at cnt=0 because H>=1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      pos <= 1'b0;
    end else if (start) begin
      cnt <= '0;
      pos <= 1'b1;
    end else if (run) begin
      if (wrap) begin
        cnt <= '0;
        pos <= ~halt;
      end else begin
        cnt <= cnt_inc;
        pos <= (cnt_inc < half);
      end
    end else begin
      cnt <= '0;
      pos <= 1'b0;
    end
  end

  // Half-cycle stretch of the high phase, only for odd ratios.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) neg <= 1'b0;
    else     neg <= div[0] & pos;
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Glitch-free run-time programmable clock divider controller.
// Start/stop and ratio changes only take effect at output-period boundaries.
// Optional macro CLK_DIV_TICK_EN adds a 'tick' output: a one-clk pulse in the
// cycle where a new output period begins (clock enable for logic on clk).
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_req,
  input  logic [CNT_W-1:0] div_val,
  output logic             div_ack,
  output logic             div_err,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div,
  output logic             clk_out
`ifdef CLK_DIV_TICK_EN
  ,
  output logic             tick
`endif
);

  state_e           state;
  logic             pend_vld;
  logic [CNT_W-1:0] pend_div;
  logic             wrap;
  logic             start;
  logic             halt;
  logic             req_take;

  assign busy  = (state != STOP);
  assign start = (state == STOP) && en;
  assign halt  = (state == DRAIN) && !en;

  // A request is only looked at when idle and not right after a response,
  // so a requester still holding div_req during the ack cycle is not re-taken.
  assign req_take = div_req && !pend_vld && !div_ack && !div_err;

  clk_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .run     (busy),
    .start   (start),
    .halt    (halt),
    .div     (cur_div),
    .wrap    (wrap),
    .clk_out (clk_out)
  );

  // Run/drain FSM, ratio handshake and pending-ratio register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= STOP;
      cur_div  <= CNT_W'(DEFAULT_DIV);
      pend_vld <= 1'b0;
      pend_div <= '0;
      div_ack  <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      div_ack <= 1'b0;
      div_err <= 1'b0;

      case (state)
        STOP:    if (en) state <= RUN;
        RUN:     if (!en) state <= DRAIN;
        DRAIN: begin
          if (en)        state <= RUN;
          else if (wrap) state <= STOP;
        end
        default: state <= STOP;
      endcase

      // Pending ratio lands on the wrap edge, including the DRAIN->STOP edge.
      if (wrap && pend_vld) begin
        cur_div  <= pend_div;
        pend_vld <= 1'b0;
        div_ack  <= 1'b1;
      end else if (req_take) begin
        if (div_val < CNT_W'(DIV_MIN)) begin
          div_err <= 1'b1;
        end else if (state == STOP) begin
          cur_div <= div_val;
          div_ack <= 1'b1;
        end else begin
          pend_vld <= 1'b1;
          pend_div <= div_val;
        end
      end
    end
  end

`ifdef CLK_DIV_TICK_EN
  // Pulse in the cycle after an edge that leaves cnt=0 with the divider active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick <= 1'b0;
    else     tick <= start || (wrap && !halt);
  end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: handshake scoreboard plus half-cycle
// waveform comparison against patterns built from the ratio.
module tb_clk_div_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       div_req;
  logic [7:0] div_val;
  logic       div_ack;
  logic       div_err;
  logic       busy;
  logic [7:0] cur_div;
  logic       clk_out;
`ifdef CLK_DIV_TICK_EN
  logic       tick;
  int         tick_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int model_cur;

  typedef struct {
    bit         is_err;
    logic [7:0] cur;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [7:0] val;
    bit         err;
  } req_vec_t;

  typedef struct {
    int n;
    int periods;
  } wave_vec_t;

  clk_div_ctrl #(.CNT_W(8), .DEFAULT_DIV(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div_req (div_req),
    .div_val (div_val),
    .div_ack (div_ack),
    .div_err (div_err),
    .busy    (busy),
    .cur_div (cur_div),
    .clk_out (clk_out)
`ifdef CLK_DIV_TICK_EN
    ,
    .tick    (tick)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Response monitor: every ack/err must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && (div_ack || div_err)) begin
      if (sb_q.size() == 0) begin
        chk("unexpected response", {62'd0, div_ack, div_err}, 64'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        chk("resp kind", {63'd0, div_err}, {63'd0, e.is_err});
        chk("resp ack",  {63'd0, div_ack}, {63'd0, !e.is_err});
        chk("resp cur_div", {56'd0, cur_div}, {56'd0, e.cur});
      end
    end
  end

  // Drive a request, wait (bounded) for the response, return cycles waited.
  task automatic do_req(input logic [7:0] v, output int lat);
    sb_t e;
    e.is_err = (v < 8'd2);
    if (!e.is_err) model_cur = v;
    e.cur = 8'(model_cur);
    sb_q.push_back(e);
    div_val = v;
    div_req = 1'b1;
    lat = 0;
    do begin
      step(1);
      lat++;
    end while (!(div_ack || div_err) && lat < 300);
    if (!(div_ack || div_err)) chk("req timeout", 64'd0, 64'd1);
    div_req = 1'b0;
  endtask

  // Expected clk_out per half-cycle: N halves high, N halves low, per period.
  function automatic logic [63:0] gen(int n, int skip, int len, int periods);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < len; i++) begin
      int k;
      k = i + skip;
      if (k < 2 * n * periods) p[i] = ((k % (2 * n)) < n);
    end
    return p;
  endfunction

  // Sample clk_out 1 time unit after each clk edge, starting at posedge+1.
  task automatic capture(input int len, output logic [63:0] p);
    p = '0;
`ifdef CLK_DIV_TICK_EN
    tick_cnt = 0;
`endif
    for (int i = 0; i < len; i++) begin
      p[i] = clk_out;
`ifdef CLK_DIV_TICK_EN
      if ((i % 2 == 0) && tick) tick_cnt++;
`endif
      #5;
    end
  endtask

  initial begin
    req_vec_t    rv[6];
    wave_vec_t   wv[6];
    logic [63:0] pat;
    int          lat;
    int          exp_lat;
    int          w;

    rv[0] = '{val: 8'd1,   err: 1'b1};
    rv[1] = '{val: 8'd0,   err: 1'b1};
    rv[2] = '{val: 8'd255, err: 1'b0};
    rv[3] = '{val: 8'd3,   err: 1'b0};
    rv[4] = '{val: 8'd3,   err: 1'b0};
    rv[5] = '{val: 8'd9,   err: 1'b0};

    wv[0] = '{n: 2, periods: 8};
    wv[1] = '{n: 3, periods: 5};
    wv[2] = '{n: 4, periods: 4};
    wv[3] = '{n: 6, periods: 2};
    wv[4] = '{n: 7, periods: 2};
    wv[5] = '{n: 8, periods: 2};

    rst = 1'b1; en = 1'b0; div_req = 1'b0; div_val = '0;
    model_cur = 3;

    // Reset state
    #2;
    chk("rst clk_out", {63'd0, clk_out}, 64'd0);
    chk("rst busy",    {63'd0, busy}, 64'd0);
    chk("rst cur_div", {56'd0, cur_div}, 64'd3);
    chk("rst ack/err", {62'd0, div_ack, div_err}, 64'd0);
    step(2);
    rst = 1'b0;
    step(1);

    // Default ratio 3
    en = 1'b1;
    step(1);
    chk("run busy", {63'd0, busy}, 64'd1);
    chk("run cur_div", {56'd0, cur_div}, 64'd3);
    capture(18, pat);
    chk("wave N=3 default", pat, gen(3, 0, 18, 3));
`ifdef CLK_DIV_TICK_EN
    chk("tick N=3 default", 64'(tick_cnt), 64'd3);
`endif

    // Mid-period change 3->4: ack only at the wrap
    step(1);
    do_req(8'd4, lat);
    chk("3->4 ack latency", 64'(lat), 64'd2);
    chk("3->4 clk_out at ack", {63'd0, clk_out}, 64'd1);
    capture(16, pat);
    chk("wave N=4 after change", pat, gen(4, 0, 16, 2));

    // Illegal ratios while running
    do_req(8'd1, lat);
    chk("err1 latency", 64'(lat), 64'd1);
    step(1);
    do_req(8'd0, lat);
    chk("err0 latency", 64'(lat), 64'd1);
    chk("cur_div after errs", {56'd0, cur_div}, 64'd4);

    // N=5, drop en at cnt=1: period completes then stops
    do_req(8'd5, lat);
    chk("4->5 clk_out at ack", {63'd0, clk_out}, 64'd1);
    step(1);
    en = 1'b0;
    capture(20, pat);
    chk("wave N=5 drain", pat, gen(5, 2, 20, 1));
    chk("drain busy", {63'd0, busy}, 64'd0);

    // Re-raise en during DRAIN: no gap
    en = 1'b1;
    step(2);
    en = 1'b0;
    step(1);
    en = 1'b1;
    capture(40, pat);
    chk("wave N=5 redrive", pat, gen(5, 4, 40, 5));
    chk("redrive busy", {63'd0, busy}, 64'd1);

    // Reset while clk_out high at N=7, with a pending change that must vanish
    do_req(8'd7, lat);
    step(1);
    div_val = 8'd4;
    div_req = 1'b1;
    step(1);
    chk("N=7 high before rst", {63'd0, clk_out}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst clk_out", {63'd0, clk_out}, 64'd0);
    chk("async rst busy", {63'd0, busy}, 64'd0);
    div_req = 1'b0;
    en = 1'b0;
    step(2);
    rst = 1'b0;
    model_cur = 3;
    step(10);
    chk("post rst cur_div", {56'd0, cur_div}, 64'd3);

    // Table: requests in STOP, ack/err next cycle
    for (int i = 0; i < 6; i++) begin
      do_req(rv[i].val, lat);
      chk($sformatf("stop req %0d latency", rv[i].val), 64'(lat), 64'd1);
      chk($sformatf("stop req %0d cur_div", rv[i].val), {56'd0, cur_div}, 64'(model_cur));
      step(1);
    end

    // Table: program ratio in STOP, run, compare waveform, stop
    for (int i = 0; i < 6; i++) begin
      int len;
      len = 2 * wv[i].n * wv[i].periods;
      do_req(8'(wv[i].n), lat);
      en = 1'b1;
      step(1);
      capture(len, pat);
      chk($sformatf("wave N=%0d", wv[i].n), pat, gen(wv[i].n, 0, len, wv[i].periods));
`ifdef CLK_DIV_TICK_EN
      chk($sformatf("tick N=%0d", wv[i].n), 64'(tick_cnt), 64'(wv[i].periods));
`endif
      en = 1'b0;
      w = 0;
      while (busy && w < 300) begin
        step(1);
        w++;
      end
      chk($sformatf("stop N=%0d busy", wv[i].n), {63'd0, busy}, 64'd0);
    end

    // en falls together with a pending change: applied at the DRAIN->STOP edge
    en = 1'b1;
    step(2);
    en = 1'b0;
    exp_lat = model_cur - 1;
    do_req(8'd6, lat);
    chk("drain+pend latency", 64'(lat), 64'(exp_lat));
    chk("drain+pend busy", {63'd0, busy}, 64'd0);
    chk("drain+pend cur_div", {56'd0, cur_div}, 64'd6);
    chk("drain+pend clk_out", {63'd0, clk_out}, 64'd0);
    step(4);
    chk("scoreboard drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
